// File: rtl/fetch_pkg.sv
// Shared definitions for the 16-bit instruction path.
//   fetch_state_e : fetch sequencer states, also visible to the decoder side
//   INSTR_W       : assembled instruction width
//   BYTE_W        : program RAM data width
package fetch_pkg;
   localparam int INSTR_W = 16;
   localparam int BYTE_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_HI,
      FETCH_LO,
      CAPTURE,
      HOLD
   } fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, the program RAM, the decoder and the
// execute-stage redirect source.
//   mem_rd_en / mem_addr / mem_rd_data : byte-wide RAM read port, 1-cycle latency
//   instr / instr_pc / instr_valid / instr_ready : instruction handshake to decoder
//   redirect_valid / redirect_pc : PC override from execute stage
// master = fetch unit, slave = the surrounding RAM/decoder/execute side.
interface instr_fetch_if #(
   parameter int ADDR_W = 12
);
   import fetch_pkg::*;

   logic                 mem_rd_en;
   logic [ADDR_W-1:0]    mem_addr;
   logic [BYTE_W-1:0]    mem_rd_data;
   logic [INSTR_W-1:0]   instr;
   logic [ADDR_W-1:0]    instr_pc;
   logic                 instr_valid;
   logic                 instr_ready;
   logic                 redirect_valid;
   logic [ADDR_W-1:0]    redirect_pc;

   modport master (
      output mem_rd_en, mem_addr, instr, instr_pc, instr_valid,
      input  mem_rd_data, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_rd_en, mem_addr, instr, instr_pc, instr_valid,
      output mem_rd_data, instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads two big-endian bytes from a synchronous
// program RAM, assembles them into one 16-bit instruction and offers it to
// the decoder over a valid/ready handshake. Owns the program counter.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   run  : 1 = keep fetching; 0 = stop after the current instruction is handed off
//   bus  : instr_fetch_if master (RAM read port, decoder handshake, redirect)
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'('h200)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           run,
   instr_fetch_if.master  bus
);

   fetch_state_e         state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [BYTE_W-1:0]    hi_q, hi_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
   logic                 instr_valid_q, instr_valid_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         hi_q          <= '0;
         instr_q       <= '0;
         instr_pc_q    <= RESET_PC;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         hi_q          <= hi_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      hi_d          = hi_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;

      unique case (state_q)
         IDLE: begin
            if (run) state_d = FETCH_HI;
         end
         FETCH_HI: begin
            state_d = FETCH_LO;
         end
         FETCH_LO: begin
            // RAM data returning now belongs to the FETCH_HI read at pc
            hi_d    = bus.mem_rd_data;
            state_d = CAPTURE;
         end
         CAPTURE: begin
            instr_d       = {hi_q, bus.mem_rd_data};
            instr_pc_d    = pc_q;
            pc_d          = pc_q + ADDR_W'(2);
            instr_valid_d = 1'b1;
            state_d       = HOLD;
         end
         HOLD: begin
            if (instr_valid_q && bus.instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = run ? FETCH_HI : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Redirect overrides the sequencer: a coincident handshake still
      // completes (valid drops either way), a held or half-fetched
      // instruction is simply abandoned.
      if (bus.redirect_valid) begin
         pc_d          = bus.redirect_pc;
         hi_d          = hi_q;
         instr_d       = instr_q;
         instr_pc_d    = instr_pc_q;
         instr_valid_d = 1'b0;
         state_d       = run ? FETCH_HI : IDLE;
      end
   end

   assign bus.mem_rd_en   = (state_q == FETCH_HI) || (state_q == FETCH_LO);
   assign bus.mem_addr    = (state_q == FETCH_LO) ? pc_q + ADDR_W'(1) : pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized run/ready/
// redirect/reset traffic, all checked every cycle against a timeline model.
module tb_instr_fetch;
   import fetch_pkg::*;

   localparam int AW    = 12;
   localparam int AMASK = 4095;

   logic clk = 1'b0;
   logic rst;
   logic run;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   instr_fetch_if #(.ADDR_W(AW)) bus ();

   instr_fetch #(.ADDR_W(AW), .RESET_PC(12'h200)) dut (
      .clk (clk),
      .rst (rst),
      .run (run),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Program RAM, 1-cycle read latency
   logic [7:0] mem [0:4095];
   logic [7:0] rd_q = 8'h00;
   always @(posedge clk) if (bus.mem_rd_en === 1'b1) rd_q <= mem[bus.mem_addr];
   assign bus.mem_rd_data = rd_q;

   // Reference model: m_step counts progress of the current fetch
   // (0 idle, 1 hi read, 2 lo read, 3 assemble, 4 offered to decoder).
   int        m_step  = 0;
   int        m_pc    = 'h200;
   int        m_ipc   = 'h200;
   int        m_instr = 0;
   bit        m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_step = 0; m_pc = 'h200; m_ipc = 'h200; m_instr = 0; m_valid = 1'b0;
      end else if (bus.redirect_valid) begin
         m_pc    = int'(bus.redirect_pc);
         m_valid = 1'b0;
         m_step  = run ? 1 : 0;
      end else if (m_step == 0) begin
         if (run) m_step = 1;
      end else if (m_step < 3) begin
         m_step = m_step + 1;
      end else if (m_step == 3) begin
         m_instr = int'({mem[m_pc], mem[(m_pc + 1) & AMASK]});
         m_ipc   = m_pc;
         m_pc    = (m_pc + 2) & AMASK;
         m_valid = 1'b1;
         m_step  = 4;
      end else if (bus.instr_ready) begin
         m_valid = 1'b0;
         m_step  = run ? 1 : 0;
      end
   end

   // Handshakes as seen on the DUT pins
   logic [15:0] hs_instr [$];
   logic [11:0] hs_pc    [$];
   always @(posedge clk)
      if (!rst && bus.instr_valid === 1'b1 && bus.instr_ready) begin
         hs_instr.push_back(bus.instr);
         hs_pc.push_back(bus.instr_pc);
      end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      check("model_valid", 32'(bus.instr_valid), 32'(m_valid));
      if (m_valid) begin
         check("model_instr", 32'(bus.instr), m_instr);
         check("model_instr_pc", 32'(bus.instr_pc), m_ipc);
      end
      check("model_rd_en", 32'(bus.mem_rd_en), 32'(m_step == 1 || m_step == 2));
      if (m_step != 3)
         check("model_mem_addr", 32'(bus.mem_addr), (m_step == 2) ? ((m_pc + 1) & AMASK) : m_pc);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (bus.instr_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(name, 32'(bus.instr_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int cnt204;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
      mem[12'h202] = 8'hAB; mem[12'h203] = 8'hCD;
      mem[12'h300] = 8'h6A; mem[12'h301] = 8'h05;
      mem[12'hFFF] = 8'h00; mem[12'h000] = 8'hE0;

      rst = 1'b1; run = 1'b0;
      bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
      @(negedge clk);
      tick();
      chk_en = 1'b1;
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_instr", 32'(bus.instr), 32'h0);
      check("rst_instr_pc", 32'(bus.instr_pc), 32'h200);
      check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'h200);

      // 1: startup, cycle 0 is the current cycle
      rst = 1'b0; run = 1'b1; bus.instr_ready = 1'b1;
      tick();
      check("c1_rd_en", 32'(bus.mem_rd_en), 32'd1);
      check("c1_addr", 32'(bus.mem_addr), 32'h200);
      tick();
      check("c2_addr", 32'(bus.mem_addr), 32'h201);
      tick();
      check("c3_valid", 32'(bus.instr_valid), 32'd0);
      tick();
      check("c4_valid", 32'(bus.instr_valid), 32'd1);
      check("c4_instr", 32'(bus.instr), 32'h1234);
      check("c4_instr_pc", 32'(bus.instr_pc), 32'h200);
      for (int i = 0; i < 4; i++) tick();
      check("c8_valid", 32'(bus.instr_valid), 32'd1);
      check("c8_instr", 32'(bus.instr), 32'hABCD);
      check("c8_instr_pc", 32'(bus.instr_pc), 32'h202);

      // 2: backpressure
      bus.instr_ready = 1'b0;
      n0 = hs_pc.size();
      for (int i = 0; i < 6; i++) begin
         tick();
         check("bp_instr", 32'(bus.instr), 32'hABCD);
         check("bp_instr_pc", 32'(bus.instr_pc), 32'h202);
         check("bp_rd_en", 32'(bus.mem_rd_en), 32'd0);
      end
      bus.instr_ready = 1'b1;
      tick();
      check("bp_one_handshake", 32'(hs_pc.size()), 32'(n0 + 1));
      check("bp_next_addr", 32'(bus.mem_addr), 32'h204);

      // 3: redirect during FETCH_LO
      tick();
      check("lo_addr", 32'(bus.mem_addr), 32'h205);
      bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h300;
      tick();
      bus.redirect_valid = 1'b0;
      check("redir_addr", 32'(bus.mem_addr), 32'h300);
      tick(); tick(); tick();
      check("redir_instr", 32'(bus.instr), 32'h6A05);
      check("redir_instr_pc", 32'(bus.instr_pc), 32'h300);
      tick();

      // 4: wrap at top of address space
      bus.redirect_valid = 1'b1; bus.redirect_pc = 12'hFFF;
      tick();
      bus.redirect_valid = 1'b0;
      check("wrap_hi_addr", 32'(bus.mem_addr), 32'hFFF);
      tick();
      check("wrap_lo_addr", 32'(bus.mem_addr), 32'h000);
      tick(); tick();
      check("wrap_instr", 32'(bus.instr), 32'h00E0);
      check("wrap_instr_pc", 32'(bus.instr_pc), 32'hFFF);
      tick();
      check("wrap_next_addr", 32'(bus.mem_addr), 32'h001);

      // 5: redirect coincident with handshake, then halt via run=0
      bus.instr_ready = 1'b0;
      wait_valid("wait_valid_5");
      n0 = hs_pc.size();
      bus.instr_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h250;
      tick();
      bus.redirect_valid = 1'b0;
      check("coinc_hs_count", 32'(hs_pc.size()), 32'(n0 + 1));
      check("coinc_hs_pc", 32'(hs_pc[$]), 32'h001);
      check("coinc_hs_instr", 32'(hs_instr[$]), 32'({mem[1], mem[2]}));
      check("coinc_next_addr", 32'(bus.mem_addr), 32'h250);
      bus.instr_ready = 1'b0;
      tick(); tick(); tick();
      check("coinc_instr_pc", 32'(bus.instr_pc), 32'h250);
      run = 1'b0;
      tick(); tick();
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("halt_rd_en", 32'(bus.mem_rd_en), 32'd0);
         check("halt_valid", 32'(bus.instr_valid), 32'd0);
      end
      run = 1'b1;
      tick();
      check("resume_addr", 32'(bus.mem_addr), 32'h252);

      // 6: reset while holding
      bus.instr_ready = 1'b0;
      wait_valid("wait_valid_6");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_hold_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_hold_instr_pc", 32'(bus.instr_pc), 32'h200);
      tick();
      check("rst_refetch_addr", 32'(bus.mem_addr), 32'h200);
      cnt204 = 0;
      foreach (hs_pc[i]) if (hs_pc[i] == 12'h204) cnt204++;
      check("no_hs_204", 32'(cnt204), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         run = ($urandom_range(0, 9) != 0);
         bus.instr_ready = 1'($urandom_range(0, 1));
         bus.redirect_valid = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       bus.redirect_pc = 12'hFFF;
            1:       bus.redirect_pc = 12'hFFE;
            default: bus.redirect_pc = 12'($urandom);
         endcase
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
